// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
package mem_ctrl_pkg;

    // Byte address that maps onto SRAM word 0.
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    // Pipeline-side and SRAM-side widths.
    localparam int DATA_W      = 32;
    localparam int WORD_ADDR_W = 17;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Access sequencer: request accepted in IDLE, low half-word, high half-word, one release cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // 32-bit word index inside the SRAM; the offset wraps modulo 2^32 and the byte lane bits are dropped.
    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr,
                                                          input logic [31:0] base);
        return WORD_ADDR_W'((byte_addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Bundle of MEM-stage request/response signals and the external SRAM pins.
interface sram_mem_controller_if;
    import mem_ctrl_pkg::*;

    logic                   mem_r_en;
    logic                   mem_w_en;
    logic [DATA_W-1:0]      alu_result;
    logic [DATA_W-1:0]      st_val;
    logic                   ready;
    logic [DATA_W-1:0]      data_memory_out;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic                   sram_dq_oe;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_we_n;

    // Controller side.
    modport slave (
        input  mem_r_en, mem_w_en, alu_result, st_val, sram_dq_in,
        output ready, data_memory_out, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    // Pipeline plus SRAM device side.
    modport master (
        output mem_r_en, mem_w_en, alu_result, st_val, sram_dq_in,
        input  ready, data_memory_out, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// Wait-state counter for one half-word SRAM phase: done is high in the last cycle of the phase.
module wait_counter #(
    parameter int W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] count_reg;

    // Count up from 0 after each clear, parking at W-1 so done stays stable until the next clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (!done) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign done = (count_reg == CW'(W - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses and stalls the pipeline meanwhile.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus
);

    state_t state_reg;
    state_t state_next;

    logic                   req;
    logic                   accept;
    logic                   phase_done;
    logic                   cnt_clear;

    logic [WORD_ADDR_W-1:0] wa_reg;
    logic [WORD_ADDR_W-1:0] wa_next;
    logic [DATA_W-1:0]      st_val_reg;
    logic [DATA_W-1:0]      st_val_next;
    logic                   is_write_reg;
    logic                   is_write_next;

    logic [SRAM_DATA_W-1:0] lo_reg;
    logic [DATA_W-1:0]      data_out_reg;

    logic [SRAM_ADDR_W-1:0] sram_addr_reg;
    logic [SRAM_DATA_W-1:0] sram_dq_out_reg;
    logic                   sram_dq_oe_reg;
    logic                   sram_we_n_reg;

    assign req    = bus.mem_r_en | bus.mem_w_en;
    assign accept = (state_reg == IDLE) && req;

    // The request is captured only when leaving IDLE; afterwards the latched copy drives the access.
    assign wa_next       = accept ? word_addr(bus.alu_result, BASE_ADDR) : wa_reg;
    assign st_val_next   = accept ? bus.st_val : st_val_reg;
    assign is_write_next = accept ? bus.mem_w_en : is_write_reg;

    // Restart the wait count whenever a phase begins; it idles cleared outside the two data phases.
    assign cnt_clear = (state_next != state_reg) || ((state_reg != LOW) && (state_reg != HIGH));

    wait_counter #(
        .W (WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .done  (phase_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a request still held there is not re-issued.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req)        state_next = LOW;
            LOW:     if (phase_done) state_next = HIGH;
            HIGH:    if (phase_done) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Stall while a request is pending in IDLE and throughout both data phases.
    assign bus.ready = ((state_reg == IDLE) && !req) || (state_reg == DONE);

    // Request latch: address, store data and operation (store wins when both enables are set).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa_reg       <= '0;
            st_val_reg   <= '0;
            is_write_reg <= 1'b0;
        end else begin
            wa_reg       <= wa_next;
            st_val_reg   <= st_val_next;
            is_write_reg <= is_write_next;
        end
    end

    // SRAM pins are registered from the next state so they change cleanly at phase boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr_reg   <= '0;
            sram_dq_out_reg <= '0;
            sram_dq_oe_reg  <= 1'b0;
            sram_we_n_reg   <= 1'b1;
        end else begin
            case (state_next)
                LOW: begin
                    sram_addr_reg   <= {wa_next, 1'b0};
                    sram_dq_out_reg <= st_val_next[15:0];
                    sram_dq_oe_reg  <= is_write_next;
                    sram_we_n_reg   <= !is_write_next;
                end
                HIGH: begin
                    sram_addr_reg   <= {wa_next, 1'b1};
                    sram_dq_out_reg <= st_val_next[31:16];
                    sram_dq_oe_reg  <= is_write_next;
                    sram_we_n_reg   <= !is_write_next;
                end
                default: begin
                    sram_dq_oe_reg  <= 1'b0;
                    sram_we_n_reg   <= 1'b1;
                end
            endcase
        end
    end

    // Read assembly: low half-word sampled at the end of LOW, full word published at the end of HIGH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_reg       <= '0;
            data_out_reg <= '0;
        end else if (!is_write_reg && phase_done) begin
            if (state_reg == LOW) begin
                lo_reg <= bus.sram_dq_in;
            end
            if (state_reg == HIGH) begin
                data_out_reg <= {bus.sram_dq_in, lo_reg};
            end
        end
    end

    assign bus.data_memory_out = data_out_reg;
    assign bus.sram_addr       = sram_addr_reg;
    assign bus.sram_dq_out     = sram_dq_out_reg;
    assign bus.sram_dq_oe      = sram_dq_oe_reg;
    assign bus.sram_we_n       = sram_we_n_reg;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: stimulus pushes expected completions and SRAM write cycles; a monitor pops and compares.
module tb_sram_mem_controller;
    import mem_ctrl_pkg::*;

    localparam int          W     = 2;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          STALL = 2 * W + 1;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] dq;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_mem_controller_if bus ();

    sram_mem_controller #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural SRAM device.
    bit [15:0] sram [0:(1<<18)-1];
    always @(posedge clk) begin
        if (bus.sram_we_n == 1'b0) sram[bus.sram_addr] <= bus.sram_dq_out;
    end
    initial begin
        bus.sram_dq_in = '0;
        forever begin
            @(negedge clk);
            bus.sram_dq_in = sram[bus.sram_addr];
        end
    end

    // Reference model: 32-bit words indexed by word address, plus the last loaded value.
    bit [31:0]   ref_mem [bit [16:0]];
    logic [31:0] last_read = '0;
    logic [31:0] exp_q [$];
    wr_t         wr_q [$];
    bit          mon_en = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit [16:0] wa_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 4;
        return off[16:0];
    endfunction

    function automatic bit [31:0] ref_rd(input bit [16:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
    endfunction

    // Monitor: a completion is the first ready-high cycle after a run of stall cycles.
    initial begin
        int stall = 0;
        logic [31:0] e;
        wr_t w;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall = 0;
            end else begin
                if (!bus.ready) begin
                    stall++;
                end else if (stall > 0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_access: got completion expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stall_cycles", 64'(stall), 64'(STALL));
                        chk("data_memory_out", bus.data_memory_out, e);
                        $display("done: stall=%0d data_memory_out=%08h expected=%08h", stall, bus.data_memory_out, e);
                    end
                    stall = 0;
                end
                if (bus.sram_we_n == 1'b0) begin
                    n_cmp++;
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %0h expected no write at %0t", bus.sram_addr, $time);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_addr", bus.sram_addr, w.addr);
                        chk("wr_dq", bus.sram_dq_out, w.dq);
                        chk("wr_oe", bus.sram_dq_oe, 1'b1);
                    end
                end
            end
        end
    end

    // Issue one access and hold the request until ready is seen high; returns at posedge+1.
    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit [16:0] wa;
        bit got;
        wa = wa_of(a);
        if (w) begin
            ref_mem[wa] = d;
            for (int i = 0; i < W; i++) wr_q.push_back('{addr: {wa, 1'b0}, dq: d[15:0]});
            for (int i = 0; i < W; i++) wr_q.push_back('{addr: {wa, 1'b1}, dq: d[31:16]});
        end else begin
            last_read = ref_rd(wa);
        end
        exp_q.push_back(last_read);
        $display("issue: %s addr=%08h st_val=%08h", w ? "store" : "load ", a, d);
        bus.mem_r_en   = r;
        bus.mem_w_en   = w;
        bus.alu_result = a;
        bus.st_val     = d;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 for 40 cycles expected completion at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", bus.ready, 1'b1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        int sel;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.alu_result = '0;
        bus.st_val     = '0;

        // Reset values, held and after release.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_we_n", bus.sram_we_n, 1'b1);
        chk("rst_oe", bus.sram_dq_oe, 1'b0);
        chk("rst_addr", bus.sram_addr, 18'h0);
        chk("rst_dq_out", bus.sram_dq_out, 16'h0);
        chk("rst_data_out", bus.data_memory_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_ready", bus.ready, 1'b1);
            chk("post_rst_we_n", bus.sram_we_n, 1'b1);
            chk("post_rst_addr", bus.sram_addr, 18'h0);
            chk("post_rst_data_out", bus.data_memory_out, 32'h0);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed: store, load back, back-to-back loads, both enables with wrapped address.
        issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        idle(1);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        issue(1'b1, 1'b0, 32'd1030, 32'h0);
        idle(2);
        issue(1'b1, 1'b1, 32'd1020, 32'h12345678);
        issue(1'b1, 1'b0, 32'd1020, 32'h0);
        idle(1);

        // Randomised traffic over a small address pool so loads hit earlier stores.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 8)
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else
                a = $urandom();
            issue((sel != 1), (sel == 1) || (sel == 2), a, $urandom());
            idle($urandom_range(0, 2));
        end

        // Reset pulsed during the high phase of a store.
        mon_en = 1'b0;
        old = ref_rd(wa_of(32'd1032));
        bus.mem_w_en   = 1'b1;
        bus.alu_result = 32'd1032;
        bus.st_val     = 32'hCAFEF00D;
        repeat (1 + W) @(posedge clk);
        #2;
        chk("high_we_n", bus.sram_we_n, 1'b0);
        chk("high_addr", bus.sram_addr, {wa_of(32'd1032), 1'b1});
        rst = 1'b0;
        bus.mem_w_en = 1'b0;
        #1;
        chk("abort_we_n", bus.sram_we_n, 1'b1);
        chk("abort_oe", bus.sram_dq_oe, 1'b0);
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_data_out", bus.data_memory_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ref_mem[wa_of(32'd1032)] = {old[31:16], 16'hF00D};
        last_read = '0;
        exp_q.delete();
        wr_q.delete();
        idle(1);
        mon_en = 1'b1;
        issue(1'b1, 1'b0, 32'd1032, 32'h0);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        idle(3);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
